// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and small combinational helpers used by the datapath.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;
        endcase
        return size;
    endfunction

    // Stores only have byte/half/word; unsigned forms exist for loads only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_LB, F3_LH, F3_LW: ok = 1'b1;
            F3_LBU, F3_LHU:      ok = ~we;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte mask and shifted store data over a
// two-word window, plus extraction and extension of load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [63:0] ld_word,
    output logic [7:0]  mask,
    output logic [63:0] st_data,
    output logic [31:0] ld_data
);

    logic [7:0]  size_mask_s;
    logic [31:0] ld_shift_s;

    // Store byte mask and data placed at the byte offset
    always_comb begin
        case (size_of(funct3))
            3'd1:    size_mask_s = 8'h01;
            3'd2:    size_mask_s = 8'h03;
            default: size_mask_s = 8'h0F;
        endcase
        mask    = size_mask_s << off;
        st_data = {32'h0000_0000, wdata} << {off, 3'b000};
    end

    // Load data aligned down from the offset, then sign/zero extended
    always_comb begin
        ld_shift_s = ld_word[{off, 3'b000} +: 32];
        case (funct3)
            F3_LB:   ld_data = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            F3_LH:   ld_data = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            F3_LW:   ld_data = ld_shift_s;
            F3_LBU:  ld_data = {24'h00_0000, ld_shift_s[7:0]};
            F3_LHU:  ld_data = {16'h0000, ld_shift_s[15:0]};
            default: ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a word-addressed async-read memory: sub-word
// stores by read-modify-write, word-crossing accesses split in two.
module lsu
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state_r, state_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r, wdata_r;
    logic [31:0] buf0_r, buf1_r;
    logic        resp_valid_r, resp_err_r;
    logic [31:0] resp_rdata_r;

    logic        req_spans_s, req_err_s, spans_s;
    logic [29:0] idx1_s;
    logic [31:0] ld_lo_s, ld_hi_s;
    logic [7:0]  mask_s;
    logic [63:0] st_data_s;
    logic [31:0] ld_data_s;

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

    // Span and legality of the incoming request and of the latched one
    always_comb begin
        req_spans_s = ({2'b00, req_addr[1:0]} + {1'b0, size_of(req_funct3)}) > 4'd4;
        req_err_s   = ~funct3_legal(req_we, req_funct3) | (~ALLOW_MISALIGNED & req_spans_s);
        spans_s     = ({2'b00, addr_r[1:0]} + {1'b0, size_of(funct3_r)}) > 4'd4;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_s = req_err_s ? RESP : ACC0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC0:    state_s = spans_s ? ACC1 : RESP;
            ACC1:    state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // The second word index wraps within the 30-bit word space
    always_comb begin
        idx1_s  = addr_r[31:2] + 30'd1;
        ld_lo_s = (state_r == ACC0) ? mem_rd : buf0_r;
        ld_hi_s = (state_r == ACC1) ? mem_rd : buf1_r;
    end

    lsu_align u_align (
        .off     (addr_r[1:0]),
        .funct3  (funct3_r),
        .wdata   (wdata_r),
        .ld_word ({ld_hi_s, ld_lo_s}),
        .mask    (mask_s),
        .st_data (st_data_s),
        .ld_data (ld_data_s)
    );

    // Memory port driven straight from state so reset drops mem_we at once
    always_comb begin
        mem_we = 1'b0;
        mem_a  = 32'h0000_0000;
        mem_wd = 32'h0000_0000;
        case (state_r)
            ACC0: begin
                mem_a  = {addr_r[31:2], 2'b00};
                mem_we = we_r;
                mem_wd = we_r ? merge_word(mem_rd, st_data_s[31:0], mask_s[3:0]) : 32'h0000_0000;
            end
            ACC1: begin
                mem_a  = {idx1_s, 2'b00};
                mem_we = we_r;
                mem_wd = we_r ? merge_word(mem_rd, st_data_s[63:32], mask_s[7:4]) : 32'h0000_0000;
            end
            default: begin
                mem_we = 1'b0;
                mem_a  = 32'h0000_0000;
                mem_wd = 32'h0000_0000;
            end
        endcase
    end

    // State, latched request, load buffers and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            we_r         <= 1'b0;
            funct3_r     <= 3'b000;
            addr_r       <= 32'h0000_0000;
            wdata_r      <= 32'h0000_0000;
            buf0_r       <= 32'h0000_0000;
            buf1_r       <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (req_valid && req_ready) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr;
                wdata_r  <= req_wdata;
            end
            if (state_r == ACC0 && !we_r) begin
                buf0_r <= mem_rd;
            end
            if (state_r == ACC1 && !we_r) begin
                buf1_r <= mem_rd;
            end
            resp_valid_r <= (state_s == RESP);
            if (state_s == RESP) begin
                case (state_r)
                    IDLE: begin
                        resp_err_r   <= 1'b1;
                        resp_rdata_r <= 32'h0000_0000;
                    end
                    ACC0, ACC1: begin
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= we_r ? 32'h0000_0000 : ld_data_s;
                    end
                    default: begin
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= 32'h0000_0000;
                    end
                endcase
            end else begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized scoreboard bench for lsu against a byte-array memory model,
// plus directed cases for reset abort, wrap and the strict-alignment build.
module tb_lsu;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;

    logic        s_req_valid, s_req_ready, s_req_we;
    logic [2:0]  s_req_funct3;
    logic [31:0] s_req_addr, s_req_wdata;
    logic        s_resp_valid, s_resp_err, s_mem_we;
    logic [31:0] s_resp_rdata, s_mem_a, s_mem_wd, s_mem_rd;

    logic [31:0] dmem   [64];
    logic [31:0] dmem_s [64];
    logic [7:0]  refb   [256];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          writes;
        int          acc;
        int          we0;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_total = 0;

    lsu u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    lsu #(.ALLOW_MISALIGNED(1'b0)) u_strict (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
        .mem_we(s_mem_we), .mem_a(s_mem_a), .mem_wd(s_mem_wd), .mem_rd(s_mem_rd)
    );

    // 256-byte memories; higher address bits alias, so 0xFFFFFFFC is word 63
    assign mem_rd   = dmem[mem_a[7:2]];
    assign s_mem_rd = dmem_s[s_mem_a[7:2]];
    always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
    always @(posedge clk) if (s_mem_we) dmem_s[s_mem_a[7:2]] <= s_mem_wd;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) we_total <= we_total + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refw(input logic [7:0] a);
        return {refb[a + 8'd3], refb[a + 8'd2], refb[a + 8'd1], refb[a]};
    endfunction

    // Reference behaviour computed byte by byte on the byte array
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input bit allow, output exp_t e);
        int size;
        bit legal, spans;
        logic [31:0] v;
        logic [7:0] ba;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        spans = (int'(addr[1:0]) + size) > 4;
        e.rdata = 32'h0; e.err = 1'b0; e.writes = 0; e.acc = 0; e.we0 = 0;
        e.lat = spans ? 3 : 2;
        if (!legal || (!allow && spans)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (we) begin
            for (int i = 0; i < size; i++) begin
                ba = addr[7:0] + 8'(i);
                refb[ba] = wd[8*i +: 8];
            end
            e.writes = spans ? 2 : 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) begin
                ba = addr[7:0] + 8'(i);
                v[8*i +: 8] = refb[ba];
            end
            if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
            if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
            e.rdata = v;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        exp_t e;
        int n;
        n = 0;
        while (!req_ready && n < 16) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL ready_timeout: req_ready=%0b, required 1", req_ready);
        end else begin
            req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
            @(posedge clk); #1;
            model(we, f3, addr, wd, 1'b1, e);
            e.acc = cyc;
            e.we0 = we_total;
            sbq.push_back(e);
            req_valid  = 1'b0;
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !req_ready) && n < 40) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
        end
    endtask

    task automatic strict_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rdata,
                              output logic err, output int lat, output int writes);
        int n;
        s_req_valid = 1'b1; s_req_we = we; s_req_funct3 = f3; s_req_addr = addr; s_req_wdata = wd;
        @(posedge clk); #1;
        s_req_valid = 1'b0; s_req_addr = $urandom;
        lat = 1; writes = 0; n = 0;
        while (!s_resp_valid && n < 10) begin
            if (s_mem_we) writes++;
            @(posedge clk); #1; lat++; n++;
        end
        checks++;
        if (!s_resp_valid) begin
            errors++;
            $display("FAIL strict_resp_timeout: resp_valid=0, required 1");
        end
        rdata = s_resp_rdata;
        err   = s_resp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt, wr;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_funct3 = 3'b000; s_req_addr = 32'h0; s_req_wdata = 32'h0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fork
            begin : monitor
                exp_t me;
                forever begin
                    @(negedge clk);
                    if (rst_n && resp_valid) begin
                        check("ready_with_resp", 32'(req_ready), 32'h0);
                        checks++;
                        if (sbq.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_resp: resp_valid=1 with no request outstanding");
                        end else begin
                            me = sbq.pop_front();
                            check("resp_rdata", resp_rdata, me.rdata);
                            check("resp_err", 32'(resp_err), 32'(me.err));
                            check("latency", 32'(cyc - me.acc + 1), 32'(me.lat));
                            check("mem_we_cycles", 32'(we_total - me.we0), 32'(me.writes));
                        end
                    end
                end
            end
        join_none

        // Strict-alignment build
        strict_req(1'b1, 3'b010, 32'h00, 32'hA5A5_5A5A, rd, er, lt, wr);
        check("s_sw_writes", 32'(wr), 32'd1);
        strict_req(1'b1, 3'b010, 32'h04, 32'h0F0F_0F0F, rd, er, lt, wr);
        strict_req(1'b1, 3'b001, 32'h03, 32'h0000_1234, rd, er, lt, wr);
        check("s_sh_span_err", 32'(er), 32'h1);
        check("s_sh_span_lat", 32'(lt), 32'd1);
        check("s_sh_span_writes", 32'(wr), 32'd0);
        check("s_sh_span_rdata", rd, 32'h0);
        check("s_word0_kept", dmem_s[0], 32'hA5A5_5A5A);
        check("s_word1_kept", dmem_s[1], 32'h0F0F_0F0F);
        strict_req(1'b0, 3'b011, 32'h00, 32'h0, rd, er, lt, wr);
        check("s_f3_011_err", 32'(er), 32'h1);
        check("s_f3_011_rdata", rd, 32'h0);
        strict_req(1'b0, 3'b010, 32'h00, 32'h0, rd, er, lt, wr);
        check("s_lw_rdata", rd, 32'hA5A5_5A5A);
        check("s_lw_lat", 32'(lt), 32'd2);
        strict_req(1'b0, 3'b001, 32'h02, 32'h0, rd, er, lt, wr);
        check("s_lh_rdata", rd, 32'hFFFF_A5A5);
        check("s_lh_err", 32'(er), 32'h0);

        // Preload every word through the unit
        for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom);

        issue(1'b1, 3'b010, 32'h10, 32'h1234_5678);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        drain();
        check("sw_word", dmem[4], 32'h1234_5678);

        issue(1'b1, 3'b010, 32'h10, 32'h1122_3344);
        issue(1'b1, 3'b000, 32'h13, 32'h0000_00AB);
        drain();
        check("sb_merge", dmem[4], 32'hAB22_3344);
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        issue(1'b0, 3'b001, 32'h10, 32'h0);

        issue(1'b1, 3'b010, 32'h0C, 32'hDDCC_BBAA);
        issue(1'b1, 3'b010, 32'h10, 32'h4433_2211);
        issue(1'b0, 3'b010, 32'h0E, 32'h0);
        issue(1'b1, 3'b001, 32'h0F, 32'h0000_BEEF);
        drain();
        check("sh_span_word0", dmem[3], 32'hEFCC_BBAA);
        check("sh_span_word1", dmem[4], 32'h4433_22BE);

        issue(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h8877_ABCD);
        issue(1'b1, 3'b010, 32'h0000_0000, 32'h1234_6655);
        drain();
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        check("wrap_acc0_mem_a", mem_a, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        check("wrap_acc1_mem_a", mem_a, 32'h0000_0000);
        drain();

        issue(1'b0, 3'b011, 32'h10, 32'h0);
        issue(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF);
        issue(1'b1, 3'b100, 32'h21, 32'hFFFF_FFFF);
        issue(1'b0, 3'b111, 32'h22, 32'h0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            issue(1'($urandom), 3'($urandom), {24'h0, 8'($urandom)}, $urandom);
        end
        drain();
        for (int w = 0; w < 64; w++) check("final_mem", dmem[w], refw(8'(w * 4)));

        // Abort a spanning store during its second access
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h22; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_acc1_mem_we", 32'(mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'h1);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_resp_rdata", resp_rdata, 32'h0);
        check("abort_resp_err", 32'(resp_err), 32'h0);
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_mem_a", mem_a, 32'h0);
        check("abort_mem_wd", mem_wd, 32'h0);
        refb[8'h22] = 8'h0D;
        refb[8'h23] = 8'hF0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_word0_written", dmem[8], refw(8'h20));
        check("abort_word1_unchanged", dmem[9], refw(8'h24));
        issue(1'b0, 3'b010, 32'h22, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the data memory (`dmemory`). It accepts one RV32I load or store request at a time from the core, using funct3 encodings LB/LH/LW/LBU/LHU/SB/SH/SW. It drives the word-addressed memory port, which has asynchronous read, synchronous write and no byte enables. It performs sub-word stores as single-cycle read-modify-write, splits word-crossing accesses into two word accesses, and returns sign/zero-extended load data or an error.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 splits word-crossing accesses; 0 rejects them with `resp_err`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle; request accepted when `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  access size/sign (RV32I encoding).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  32  formatted load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned (when disallowed) or illegal funct3.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  32  memory byte address, always word aligned (bits [1:0] = 0).
- `mem_wd`  out  32  memory write word.
- `mem_rd`  in  32  memory read word, combinational from `mem_a`.

## Operation
- States: IDLE, ACC0, ACC1, RESP. `req_ready` = (state == IDLE).
- IDLE: on accept, latch `we`, `funct3`, `addr`, `wdata`.
  - Illegal funct3 goes to RESP with err. Loads: 011, 110, 111 are illegal. Stores: only 000/001/010 are legal.
  - Misaligned access with `ALLOW_MISALIGNED=0` goes to RESP with err.
  - Otherwise go to ACC0.
- Access size is 1/2/4 bytes and off = `addr[1:0]`. The access spans two words iff off + size > 4.
- ACC0: `mem_a` = {addr[31:2],2'b00}.
  - Load: capture `mem_rd` into buf0.
  - Store: `mem_we`=1 and `mem_wd` = merge(`mem_rd`, lower word of shifted data/mask).
  - Next state is ACC1 if the access spans, else RESP.
- ACC1: `mem_a` = {addr[31:2]+1, 2'b00}, with 30-bit index wrap (0xFFFFFFFC goes to 0x00000000). It does the same as ACC0 using buf1 and the upper word. Next state is RESP.
- Merge rules:
  - 8-bit mask = size_mask << off.
  - 64-bit data = zero-extended wdata << 8·off.
  - In each written word, bytes with mask=1 take new data; the rest keep `mem_rd`.
- Load format: take {buf1,buf0} >> 8·off, then use the low 8/16/32 bits. LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: `resp_valid`=1 for one cycle with `resp_rdata`/`resp_err` valid, then IDLE.
- No memory write ever occurs for an errored request.
- `mem_we`, `mem_a` and `mem_wd` are combinational from state and latched fields. `mem_we`=0 outside ACC0/ACC1.

## Timing
- Reset values:
  - state IDLE, `req_ready`=1
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0
  - `mem_we`=0, `mem_a`=0, `mem_wd`=0
  - buf0/buf1 = 0
- Latency, with acceptance edge = cycle 0:
  - single-word access: `resp_valid` in cycle 2
  - spanning access: cycle 3
  - error: cycle 1
- Throughput: next request can be accepted in the cycle after RESP, while IDLE.
- `req_*` is sampled only at acceptance. Later changes are ignored.
- Reset mid-operation aborts immediately and `mem_we` drops asynchronously. If a spanning store is aborted after ACC0, word0 stays written and word1 stays unwritten; this is accepted behaviour.
- `resp_valid` and `req_ready` are never high in the same cycle.

## Structure
- Package `lsu_pkg`:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW
  - state enum `lsu_state_t`
  - function `size_of(funct3)` returning 1/2/4
- Sub-module `lsu_align`: purely combinational. It computes the byte mask, shifted store data and formatted load data from off/funct3. The top level holds the FSM and registers.

## Test plan
- Reset: assert `rst_n`=0 during ACC1 of a spanning SW → all outputs take reset values, IDLE next, word at addr+4 unchanged.
- SW 0x12345678 @0x10, then LW @0x10 → `resp_rdata`=0x12345678, `resp_valid` in cycle 2 after accept, `mem_we` high exactly one cycle.
- Word 0x11223344 @0x10; SB 0xAB @0x13 → word 0xAB223344; LB @0x13 → 0xFFFFFFAB; LBU @0x13 → 0x000000AB; LH @0x10 → 0x00003344.
- Words 0xDDCCBBAA @0x0C and 0x44332211 @0x10; LW @0x0E → 0x2211DDCC in cycle 3. SH 0xBEEF @0x0F → words 0xEFCCBBAA and 0x443322BE.
- `ALLOW_MISALIGNED`=0: SH @0x03 → `resp_err`=1 in cycle 1, no `mem_we`, memory unchanged. Load with funct3=011 → `resp_err`=1, `resp_rdata`=0.
- Wrap: words 0x8877xxxx @0xFFFFFFFC and 0xxxxx6655 @0x00000000; LW @0xFFFFFFFE → 0x66558877, ACC1 `mem_a`=0x00000000.
